// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - splits a UART byte stream into single-byte commands and escape-started image frames
module uart_frame_parser #(
  parameter int         RES_BYTES = 2,
  parameter int         PIX_BYTES = 1,
  parameter logic [7:0] ESC_CODE  = 8'h00
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [7:0]             cmd_out,
  output logic                   cmd_valid,
  output logic [8*PIX_BYTES-1:0] pix_data,
  output logic                   pix_valid,
  output logic                   pix_en,
  output logic [8*RES_BYTES-1:0] img_vres,
  output logic [8*RES_BYTES-1:0] img_hres,
  output logic                   hdr_done,
  output logic                   frame_done,
  output logic                   hdr_err
);

  localparam int RW   = 8 * RES_BYTES;
  localparam int PW   = 8 * PIX_BYTES;
  localparam int MAXB = (RES_BYTES > PIX_BYTES) ? RES_BYTES : PIX_BYTES;
  localparam int CW   = $clog2(MAXB + 1);

  localparam logic [CW-1:0] RES_LAST = CW'(RES_BYTES - 1);
  localparam logic [CW-1:0] PIX_LAST = CW'(PIX_BYTES - 1);

  localparam logic [1:0] S_CMD   = 2'd0;
  localparam logic [1:0] S_HDR_V = 2'd1;
  localparam logic [1:0] S_HDR_H = 2'd2;
  localparam logic [1:0] S_PIX   = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   byte_cnt;
  logic [RW-1:0]   vres_stage;
  logic [RW-1:0]   hres_stage;
  logic [PW-1:0]   pix_stage;
  logic [2*RW-1:0] total;
  logic [2*RW-1:0] pix_cnt;

  // Staging registers shift MSB first; the top byte falls off the wide shift vector.
  logic [RW+7:0]   vres_shift;
  logic [RW+7:0]   hres_shift;
  logic [PW+7:0]   pix_shift;
  logic [RW-1:0]   hres_next;
  logic [2*RW-1:0] pix_cnt_inc;
  logic [2*RW-1:0] product;

  assign vres_shift  = {vres_stage, rx_data};
  assign hres_shift  = {hres_stage, rx_data};
  assign pix_shift   = {pix_stage, rx_data};
  assign hres_next   = hres_shift[RW-1:0];
  assign pix_cnt_inc = pix_cnt + 1'b1;
  // Full-width product so large resolutions never truncate the pixel total.
  assign product     = {{RW{1'b0}}, vres_stage} * {{RW{1'b0}}, hres_next};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_CMD;
      byte_cnt   <= '0;
      vres_stage <= '0;
      hres_stage <= '0;
      pix_stage  <= '0;
      total      <= '0;
      pix_cnt    <= '0;
      cmd_out    <= '0;
      cmd_valid  <= 1'b0;
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      pix_en     <= 1'b0;
      img_vres   <= '0;
      img_hres   <= '0;
      hdr_done   <= 1'b0;
      frame_done <= 1'b0;
      hdr_err    <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      pix_valid  <= 1'b0;
      hdr_done   <= 1'b0;
      frame_done <= 1'b0;
      hdr_err    <= 1'b0;
      if (rx_valid) begin
        case (state)
          S_CMD: begin
            if (rx_data == ESC_CODE) begin
              state    <= S_HDR_V;
              byte_cnt <= '0;
            end else begin
              cmd_out   <= rx_data;
              cmd_valid <= 1'b1;
            end
          end
          S_HDR_V: begin
            vres_stage <= vres_shift[RW-1:0];
            if (byte_cnt == RES_LAST) begin
              byte_cnt <= '0;
              state    <= S_HDR_H;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          S_HDR_H: begin
            hres_stage <= hres_next;
            if (byte_cnt == RES_LAST) begin
              byte_cnt <= '0;
              if (vres_stage == '0 || hres_next == '0) begin
                hdr_err <= 1'b1;
                state   <= S_CMD;
              end else begin
                img_vres <= vres_stage;
                img_hres <= hres_next;
                hdr_done <= 1'b1;
                pix_en   <= 1'b1;
                total    <= product;
                pix_cnt  <= '0;
                state    <= S_PIX;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          S_PIX: begin
            pix_stage <= pix_shift[PW-1:0];
            if (byte_cnt == PIX_LAST) begin
              byte_cnt  <= '0;
              pix_data  <= pix_shift[PW-1:0];
              pix_valid <= 1'b1;
              pix_cnt   <= pix_cnt_inc;
              if (pix_cnt_inc == total) begin
                frame_done <= 1'b1;
                pix_en     <= 1'b0;
                state      <= S_CMD;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          default: state <= S_CMD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - self-checking bench for uart_frame_parser
module tb_uart_frame_parser;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  cmd_out;
  logic        cmd_valid;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_en;
  logic [15:0] img_vres;
  logic [15:0] img_hres;
  logic        hdr_done;
  logic        frame_done;
  logic        hdr_err;

  uart_frame_parser #(.RES_BYTES(2), .PIX_BYTES(2), .ESC_CODE(8'h00)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_out(cmd_out), .cmd_valid(cmd_valid), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_en(pix_en), .img_vres(img_vres),
    .img_hres(img_hres), .hdr_done(hdr_done), .frame_done(frame_done),
    .hdr_err(hdr_err)
  );

  logic [7:0]  b_data;
  logic        b_valid;
  logic [7:0]  b_cmd_out;
  logic        b_cmd_valid;
  logic [23:0] b_pix_data;
  logic        b_pix_valid;
  logic        b_pix_en;
  logic [7:0]  b_vres;
  logic [7:0]  b_hres;
  logic        b_hdr_done;
  logic        b_frame_done;
  logic        b_hdr_err;

  uart_frame_parser #(.RES_BYTES(1), .PIX_BYTES(3), .ESC_CODE(8'h00)) dut1 (
    .CLK(CLK), .RST(RST), .rx_data(b_data), .rx_valid(b_valid),
    .cmd_out(b_cmd_out), .cmd_valid(b_cmd_valid), .pix_data(b_pix_data),
    .pix_valid(b_pix_valid), .pix_en(b_pix_en), .img_vres(b_vres),
    .img_hres(b_hres), .hdr_done(b_hdr_done), .frame_done(b_frame_done),
    .hdr_err(b_hdr_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference model: byte queues per header/pixel and a countdown of remaining pixels.
  int          m_mode;
  logic [7:0]  m_q[$];
  longint      m_left;
  logic [7:0]  e_cmd;
  logic        e_cv, e_pv, e_pe, e_hd, e_fd, e_he;
  logic [15:0] e_pd, e_vr, e_hr;

  function automatic longint q_val(int first, int n);
    longint acc = 0;
    for (int k = 0; k < n; k++) acc = acc * 256 + longint'(m_q[first + k]);
    return acc;
  endfunction

  task automatic model_step(input logic rst, input logic v, input logic [7:0] d);
    longint vr, hr, px;
    e_cv = 0; e_pv = 0; e_hd = 0; e_fd = 0; e_he = 0;
    if (rst) begin
      e_cmd = 0; e_pd = 0; e_pe = 0; e_vr = 0; e_hr = 0;
      m_mode = 0; m_q.delete();
    end else if (v) begin
      case (m_mode)
        0: if (d == 8'h00) begin m_mode = 1; m_q.delete(); end
           else begin e_cmd = d; e_cv = 1; end
        1: begin
          m_q.push_back(d);
          if (m_q.size() == 4) begin
            vr = q_val(0, 2);
            hr = q_val(2, 2);
            m_q.delete();
            if (vr == 0 || hr == 0) begin e_he = 1; m_mode = 0; end
            else begin
              e_vr = 16'(vr); e_hr = 16'(hr); e_hd = 1; e_pe = 1;
              m_left = vr * hr; m_mode = 2;
            end
          end
        end
        default: begin
          m_q.push_back(d);
          if (m_q.size() == 2) begin
            px = q_val(0, 2);
            m_q.delete();
            e_pd = 16'(px); e_pv = 1;
            m_left--;
            if (m_left == 0) begin e_fd = 1; e_pe = 0; m_mode = 0; end
          end
        end
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".cmd_out"},    32'(cmd_out),    32'(e_cmd));
    chk({tag, ".cmd_valid"},  32'(cmd_valid),  32'(e_cv));
    chk({tag, ".pix_data"},   32'(pix_data),   32'(e_pd));
    chk({tag, ".pix_valid"},  32'(pix_valid),  32'(e_pv));
    chk({tag, ".pix_en"},     32'(pix_en),     32'(e_pe));
    chk({tag, ".img_vres"},   32'(img_vres),   32'(e_vr));
    chk({tag, ".img_hres"},   32'(img_hres),   32'(e_hr));
    chk({tag, ".hdr_done"},   32'(hdr_done),   32'(e_hd));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(e_fd));
    chk({tag, ".hdr_err"},    32'(hdr_err),    32'(e_he));
  endtask

  task automatic drive(input logic rst, input logic v, input logic [7:0] d);
    @(negedge CLK);
    RST = rst; rx_valid = v; rx_data = d;
    @(posedge CLK);
    #1;
    model_step(rst, v, d);
    RST = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic drive1(input logic v, input logic [7:0] d);
    @(negedge CLK);
    b_valid = v; b_data = d;
    @(posedge CLK);
    #1;
    b_valid = 1'b0;
  endtask

  typedef struct {
    logic v; logic [7:0] d;
    logic cv; logic [7:0] co; logic hd; logic he; logic pv; logic [15:0] pd;
    logic fd; logic pe; logic [15:0] vr; logic [15:0] hr;
  } vec_t;

  function automatic vec_t mk(logic v, logic [7:0] d, logic cv, logic [7:0] co, logic hd,
                              logic he, logic pv, logic [15:0] pd, logic fd, logic pe,
                              logic [15:0] vr, logic [15:0] hr);
    vec_t r;
    r.v = v; r.d = d; r.cv = cv; r.co = co; r.hd = hd; r.he = he;
    r.pv = pv; r.pd = pd; r.fd = fd; r.pe = pe; r.vr = vr; r.hr = hr;
    return r;
  endfunction

  initial begin
    vec_t tbl[$];
    logic [7:0] d;
    logic [23:0] pv;
    logic rs, vv;

    //                 v  d      cv co     hd he pv pd        fd pe vr  hr
    tbl.push_back(mk(1, 8'h41, 1, 8'h41, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h42, 1, 8'h42, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'hFF, 0, 8'h42, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 8'h42, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 8'h42, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h02, 0, 8'h42, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 8'h42, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h03, 0, 8'h42, 1, 0, 0, 16'h0000, 0, 1, 2, 3));
    tbl.push_back(mk(1, 8'hAB, 0, 8'h42, 0, 0, 0, 16'h0000, 0, 1, 2, 3));
    tbl.push_back(mk(1, 8'hCD, 0, 8'h42, 0, 0, 1, 16'hABCD, 0, 1, 2, 3));
    tbl.push_back(mk(1, 8'h12, 0, 8'h42, 0, 0, 0, 16'hABCD, 0, 1, 2, 3));
    tbl.push_back(mk(1, 8'h34, 0, 8'h42, 0, 0, 1, 16'h1234, 0, 1, 2, 3));
    tbl.push_back(mk(1, 8'h00, 0, 8'h42, 0, 0, 0, 16'h1234, 0, 1, 2, 3));
    tbl.push_back(mk(1, 8'h00, 0, 8'h42, 0, 0, 1, 16'h0000, 0, 1, 2, 3));
    tbl.push_back(mk(1, 8'h56, 0, 8'h42, 0, 0, 0, 16'h0000, 0, 1, 2, 3));
    tbl.push_back(mk(0, 8'h00, 0, 8'h42, 0, 0, 0, 16'h0000, 0, 1, 2, 3));
    tbl.push_back(mk(1, 8'h78, 0, 8'h42, 0, 0, 1, 16'h5678, 0, 1, 2, 3));
    tbl.push_back(mk(1, 8'h9A, 0, 8'h42, 0, 0, 0, 16'h5678, 0, 1, 2, 3));
    tbl.push_back(mk(1, 8'hBC, 0, 8'h42, 0, 0, 1, 16'h9ABC, 0, 1, 2, 3));
    tbl.push_back(mk(1, 8'hDE, 0, 8'h42, 0, 0, 0, 16'h9ABC, 0, 1, 2, 3));
    tbl.push_back(mk(1, 8'hF0, 0, 8'h42, 0, 0, 1, 16'hDEF0, 1, 0, 2, 3));
    tbl.push_back(mk(1, 8'h55, 1, 8'h55, 0, 0, 0, 16'hDEF0, 0, 0, 2, 3));
    tbl.push_back(mk(1, 8'h00, 0, 8'h55, 0, 0, 0, 16'hDEF0, 0, 0, 2, 3));
    tbl.push_back(mk(1, 8'h00, 0, 8'h55, 0, 0, 0, 16'hDEF0, 0, 0, 2, 3));
    tbl.push_back(mk(1, 8'h00, 0, 8'h55, 0, 0, 0, 16'hDEF0, 0, 0, 2, 3));
    tbl.push_back(mk(1, 8'h00, 0, 8'h55, 0, 0, 0, 16'hDEF0, 0, 0, 2, 3));
    tbl.push_back(mk(1, 8'h05, 0, 8'h55, 0, 1, 0, 16'hDEF0, 0, 0, 2, 3));
    tbl.push_back(mk(1, 8'h10, 1, 8'h10, 0, 0, 0, 16'hDEF0, 0, 0, 2, 3));

    RST = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; b_valid = 1'b0; b_data = 8'h00;
    m_mode = 0; m_left = 0;
    drive(1, 1, 8'h41);
    drive(1, 1, 8'h41);
    chk("rst.cmd_valid", 32'(cmd_valid), 0);
    chk("rst.cmd_out",   32'(cmd_out),   0);
    chk("rst.pix_en",    32'(pix_en),    0);
    chk("rst.img_vres",  32'(img_vres),  0);
    chk("rst.b_pix_en",  32'(b_pix_en),  0);
    check_model("rst");

    for (int i = 0; i < tbl.size(); i++) begin
      string t;
      t = $sformatf("tbl%0d", i);
      drive(0, tbl[i].v, tbl[i].d);
      chk({t, ".cmd_valid"},  32'(cmd_valid),  32'(tbl[i].cv));
      chk({t, ".cmd_out"},    32'(cmd_out),    32'(tbl[i].co));
      chk({t, ".hdr_done"},   32'(hdr_done),   32'(tbl[i].hd));
      chk({t, ".hdr_err"},    32'(hdr_err),    32'(tbl[i].he));
      chk({t, ".pix_valid"},  32'(pix_valid),  32'(tbl[i].pv));
      chk({t, ".pix_data"},   32'(pix_data),   32'(tbl[i].pd));
      chk({t, ".frame_done"}, 32'(frame_done), 32'(tbl[i].fd));
      chk({t, ".pix_en"},     32'(pix_en),     32'(tbl[i].pe));
      chk({t, ".img_vres"},   32'(img_vres),   32'(tbl[i].vr));
      chk({t, ".img_hres"},   32'(img_hres),   32'(tbl[i].hr));
    end

    // Reset mid-frame, asserted together with a valid byte.
    drive(0, 1, 8'h00); drive(0, 1, 8'h00); drive(0, 1, 8'h02);
    drive(0, 1, 8'h00); drive(0, 1, 8'h03);
    check_model("midrst.hdr");
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 8'($urandom_range(0, 255)));
      check_model("midrst.pix");
    end
    drive(1, 1, 8'h00);
    chk("midrst.cmd_out",  32'(cmd_out),  0);
    chk("midrst.pix_data", 32'(pix_data), 0);
    chk("midrst.pix_en",   32'(pix_en),   0);
    chk("midrst.img_vres", 32'(img_vres), 0);
    chk("midrst.img_hres", 32'(img_hres), 0);
    check_model("midrst.rst");
    drive(0, 1, 8'h07);
    chk("midrst.cmd_valid", 32'(cmd_valid), 1);
    chk("midrst.cmd_out7",  32'(cmd_out),    8'h07);
    check_model("midrst.cmd");

    for (int n = 0; n < 4000; n++) begin
      rs = ($urandom_range(0, 399) == 0);
      vv = ($urandom_range(0, 3) != 0);
      case (m_mode)
        0: d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        1: d = (m_q.size() % 2 == 0) ? 8'h00 : 8'($urandom_range(0, 4));
        default: d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      endcase
      drive(rs, vv, d);
      check_model("rand");
    end

    // 17*19 = 323 pixels: exceeds the 8-bit field range, so the count must not wrap.
    drive1(1, 8'h00);
    chk("wide.esc_cmd_valid", 32'(b_cmd_valid), 0);
    drive1(1, 8'h11);
    drive1(1, 8'h13);
    chk("wide.hdr_done", 32'(b_hdr_done), 1);
    chk("wide.vres",     32'(b_vres),     8'h11);
    chk("wide.hres",     32'(b_hres),     8'h13);
    chk("wide.pix_en",   32'(b_pix_en),   1);
    for (int k = 1; k <= 323; k++) begin
      for (int j = 0; j < 3; j++) begin
        d = 8'($urandom_range(0, 255));
        pv = {pv[15:0], d};
        drive1(1, d);
        if (j < 2) chk("wide.pix_valid_lo", 32'(b_pix_valid), 0);
      end
      chk("wide.pix_valid",  32'(b_pix_valid),  1);
      chk("wide.pix_data",   32'(b_pix_data),   32'(pv));
      chk("wide.frame_done", 32'(b_frame_done), (k == 323) ? 1 : 0);
      chk("wide.pix_en_run", 32'(b_pix_en),     (k == 323) ? 0 : 1);
    end
    drive1(1, 8'h07);
    chk("wide.after_cmd_valid", 32'(b_cmd_valid), 1);
    chk("wide.after_cmd_out",   32'(b_cmd_out),   8'h07);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Parametrised successor to the UART byte handler; sits between the UART receiver and the command decoder / pixel buffer.
- Splits the received byte stream into single-byte commands and escape-introduced image frames.
- A frame is a multi-byte vres/hres header followed by exactly hres*vres multi-byte pixels.
- Leaves pixel mode on its own after the last pixel, so no closing escape byte is needed.

Parameters:
- RES_BYTES, default 2: bytes per resolution field, MSB first; field width RW = 8*RES_BYTES.
- PIX_BYTES, default 1: bytes per pixel, MSB first; pixel width PW = 8*PIX_BYTES.
- ESC_CODE, default 8'h00: byte that starts a frame header when seen in command mode.

Ports:
- CLK  in  1  board clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe per received byte; back-to-back strobes on consecutive cycles are legal.
- cmd_out  out  8  last command byte.
- cmd_valid  out  1  one-cycle pulse when cmd_out is updated.
- pix_data  out  PW  assembled pixel.
- pix_valid  out  1  one-cycle pulse per complete pixel.
- pix_en  out  1  high while in pixel mode.
- img_vres  out  RW  vertical resolution of the last accepted header.
- img_hres  out  RW  horizontal resolution of the last accepted header.
- hdr_done  out  1  one-cycle pulse when a header is accepted.
- frame_done  out  1  one-cycle pulse on the last pixel of a frame.
- hdr_err  out  1  one-cycle pulse when a header is rejected because a field is zero.

Behaviour:
- Reset: every output is 0; FSM goes to CMD; byte counter, pixel counter and staging registers are cleared.
- RST is honoured in any state, including mid-header and mid-frame, and overrides a simultaneous rx_valid.
- All outputs are registered. Every response appears the cycle after the rx_valid that caused it.
- Pulse outputs are high for exactly one cycle. Data outputs hold their value between pulses.
- Bytes arriving with rx_valid=0 are ignored, and no state advances.

State CMD:
- Byte != ESC_CODE: cmd_out <= byte, cmd_valid pulses; stay in CMD.
- Byte == ESC_CODE: go to HDR_V with the byte counter at 0. No cmd_valid pulse.

State HDR_V:
- Shift RES_BYTES bytes, MSB first, into vres_stage.
- After the last byte, go to HDR_H. ESC_CODE here is ordinary data.

State HDR_H:
- Shift RES_BYTES bytes into hres_stage.
- On the last byte, if either field is zero: hdr_err pulses, go to CMD. img_* and pix_en are unchanged.
- Otherwise:
  - img_vres/img_hres <= staged values, and hdr_done pulses.
  - pix_en <= 1, total <= vres*hres (width 2*RW, full product, no truncation), pixel counter <= 0.
  - Go to PIX.

State PIX:
- Every byte is pixel data; ESC_CODE is not special here.
- Bytes are shifted MSB first. On the PIX_BYTES-th byte: pix_data <= assembled value, pix_valid pulses, pixel counter increments.
- When the counter reaches total on this pixel, in the same output cycle:
  - frame_done pulses together with pix_valid;
  - pix_en <= 0;
  - go to CMD.
- The next byte after that is parsed as a command.

Other rules:
- pix_en changes only on header acceptance, frame completion or RST.
- No timeout. A partially received header or frame waits indefinitely until more bytes arrive or RST.
- The pixel counter is 2*RW bits wide; with a nonzero total it cannot wrap before frame_done.

Test Plan (RES_BYTES=2, PIX_BYTES=2, ESC_CODE=8'h00 unless noted):
- Bytes 8'h41, 8'h42 on back-to-back cycles -> cmd_valid pulses on two consecutive cycles with cmd_out 8'h41 then 8'h42; pix_en stays 0.
- 00, 00 02, 00 03, then 12 pixel bytes 0xAB,0xCD,... -> img_vres=2, img_hres=3 and hdr_done pulse; then 6 pix_valid pulses, first pix_data=16'hABCD. The sixth pulse coincides with frame_done; pix_en falls that cycle; a following 8'h55 gives cmd_valid with cmd_out=8'h55.
- Header 00, 00 00, 00 05 -> hdr_err pulse; img_* keep their prior values; pix_en=0; a following 8'h10 is a command.
- In PIX, pixel bytes 00,00 -> pix_valid with pix_data=16'h0000; no new header is started.
- RST asserted after 3 of 6 pixels -> the next cycle shows all outputs 0 and FSM in CMD; then 8'h07 gives cmd_valid with cmd_out=8'h07.
- Rerun with RES_BYTES=1, PIX_BYTES=3: header 00, FF, FF -> total=65025; the pixel counter reaches 65025 without wrap, and frame_done fires only on pixel 65025.
